// File: rtl/stream_grant_arbiter.sv
// N-port stream arbiter: fixed-priority or round-robin, optional grant blocking, registered outputs.
// Define ARBITER_ASSERT_EN to enable simulation-only protocol checks.
module stream_grant_arbiter #(
  parameter int    PORTS        = 4,
  parameter string TYPE         = "PRIORITY",
  parameter string BLOCK        = "NONE",
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [PORTS-1:0]                           request,
  input  logic [PORTS-1:0]                           acknowledge,
  output logic [PORTS-1:0]                           grant,
  output logic                                       grant_valid,
  output logic [(PORTS > 1 ? $clog2(PORTS) : 1)-1:0] grant_encoded
);

  localparam int W        = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam bit LSB_HIGH = (LSB_PRIORITY == "HIGH");
  localparam bit RR       = (TYPE == "ROUND_ROBIN");
  localparam bit BLK_REQ  = (BLOCK == "REQUEST");
  localparam bit BLK_ACK  = (BLOCK == "ACKNOWLEDGE");

  logic [PORTS-1:0] mask, mask_next, masked, grant_next;
  logic             grant_valid_next, hold;
  logic [W-1:0]     grant_encoded_next, winner;

  // Scan towards the preferred end so the last hit is the winner.
  function automatic logic [W-1:0] encode(input logic [PORTS-1:0] v);
    logic [W-1:0] idx;
    int unsigned  j;
    idx = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      j = LSB_HIGH ? (unsigned'(PORTS) - 1 - i) : i;
      if (v[j]) idx = W'(j);
    end
    return idx;
  endfunction

  always_comb begin
    masked             = request & mask;
    winner             = (RR && (|masked)) ? encode(masked) : encode(request);
    hold               = (BLK_REQ && (|(grant & request))) ||
                         (BLK_ACK && grant_valid && !(|(grant & acknowledge)));
    grant_next         = grant;
    grant_valid_next   = grant_valid;
    grant_encoded_next = grant_encoded;
    mask_next          = mask;
    if (!hold) begin
      if (|request) begin
        grant_valid_next   = 1'b1;
        grant_encoded_next = winner;
        for (int unsigned i = 0; i < PORTS; i++) begin
          grant_next[i] = (W'(i) == winner);
          mask_next[i]  = LSB_HIGH ? (W'(i) > winner) : (W'(i) < winner);
        end
      end else begin
        grant_next         = '0;
        grant_valid_next   = 1'b0;
        grant_encoded_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '0;
    end else begin
      grant         <= grant_next;
      grant_valid   <= grant_valid_next;
      grant_encoded <= grant_encoded_next;
      mask          <= mask_next;
    end
  end

`ifdef ARBITER_ASSERT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!$onehot0(grant)) $error("grant not one-hot: %b", grant);
      if (grant_valid != (|grant)) $error("grant_valid %b inconsistent with grant %b", grant_valid, grant);
      if (grant_valid && !grant[grant_encoded]) $error("grant_encoded %0d does not match grant %b", grant_encoded, grant);
      if (BLK_ACK && (|(acknowledge & ~grant))) $error("acknowledge %b on non-granted port, grant %b", acknowledge, grant);
    end
  end
`endif

endmodule

// File: tb/tb_stream_grant_arbiter.sv
// Self-checking bench: several arbiter configurations share stimulus and are compared to a rotating-pointer model.
module tb_stream_grant_arbiter;

  localparam int N  = 4;
  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [N-1:0] request, acknowledge;
  logic [N-1:0] g  [NI];
  logic         gv [NI];
  logic [1:0]   ge [NI];
  logic         one_g, one_gv;
  logic         one_ge;

  // Configuration of each instance: round-robin?, lowest index wins?, block mode (0 none, 1 request, 2 ack)
  int rr_m  [NI] = '{0, 0, 1, 1, 1};
  int hi_m  [NI] = '{1, 0, 1, 0, 1};
  int blk_m [NI] = '{0, 0, 2, 1, 0};

  int gidx [NI];
  int last [NI];
  logic one_exp;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_grant_arbiter #(.PORTS(4), .TYPE("PRIORITY"), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) u_pri_hi (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[0]), .grant_valid(gv[0]), .grant_encoded(ge[0]));
  stream_grant_arbiter #(.PORTS(4), .TYPE("PRIORITY"), .BLOCK("NONE"), .LSB_PRIORITY("LOW")) u_pri_lo (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[1]), .grant_valid(gv[1]), .grant_encoded(ge[1]));
  stream_grant_arbiter #(.PORTS(4), .TYPE("ROUND_ROBIN"), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("HIGH")) u_rr_ack (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[2]), .grant_valid(gv[2]), .grant_encoded(ge[2]));
  stream_grant_arbiter #(.PORTS(4), .TYPE("ROUND_ROBIN"), .BLOCK("REQUEST"), .LSB_PRIORITY("LOW")) u_rr_req (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[3]), .grant_valid(gv[3]), .grant_encoded(ge[3]));
  stream_grant_arbiter #(.PORTS(4), .TYPE("ROUND_ROBIN"), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) u_rr_none (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[4]), .grant_valid(gv[4]), .grant_encoded(ge[4]));
  stream_grant_arbiter #(.PORTS(1), .TYPE("PRIORITY"), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) u_one (
    .clk(clk), .rst(rst), .request(request[0]), .acknowledge(acknowledge[0]),
    .grant(one_g), .grant_valid(one_gv), .grant_encoded(one_ge));

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin is modelled as a cyclic search starting just past the last winner.
  function automatic void model_step(input logic r, input logic [N-1:0] req, input logic [N-1:0] ack);
    for (int k = 0; k < NI; k++) begin
      bit hold;
      int w;
      if (!r) begin
        gidx[k] = -1;
        last[k] = hi_m[k] ? -1 : N;
        continue;
      end
      hold = (blk_m[k] == 1 && gidx[k] >= 0 && req[gidx[k]]) ||
             (blk_m[k] == 2 && gidx[k] >= 0 && !ack[gidx[k]]);
      if (hold) continue;
      w = -1;
      if (rr_m[k] != 0) begin
        for (int s = 1; s <= N && w < 0; s++) begin
          int idx;
          idx = (last[k] + (hi_m[k] ? s : -s) + 2 * N) % N;
          if (req[idx]) w = idx;
        end
      end else if (hi_m[k] != 0) begin
        for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
      end else begin
        for (int i = 0; i < N; i++) if (req[i]) w = i;
      end
      gidx[k] = w;
      if (w >= 0) last[k] = w;
    end
  endfunction

  task automatic cycle(input logic r, input logic [N-1:0] req, input logic [N-1:0] ack);
    rst = r; request = req; acknowledge = ack;
    @(posedge clk);
    model_step(r, req, ack);
    one_exp = r & req[0];
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("grant[%0d]", k), g[k], (gidx[k] < 0) ? 0 : (1 << gidx[k]));
      check($sformatf("valid[%0d]", k), gv[k], (gidx[k] < 0) ? 0 : 1);
      check($sformatf("encoded[%0d]", k), ge[k], (gidx[k] < 0) ? 0 : gidx[k]);
    end
    check("one_grant", one_g, one_exp);
    check("one_valid", one_gv, one_exp);
    check("one_encoded", one_ge, 0);
  endtask

  initial begin
    logic [N-1:0] rr_seq [5];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < NI; k++) begin gidx[k] = -1; last[k] = 0; end
    rst = 1'b0; request = '0; acknowledge = '0;
    @(negedge clk);
    cycle(1'b0, 4'b1111, 4'b1111);
    check("reset_grant", g[2], 0);
    check("reset_valid", gv[4], 0);

    // Fixed priority in both directions
    cycle(1'b1, 4'b1010, '0);
    check("pri_hi_grant", g[0], 4'b0010);
    check("pri_hi_enc", ge[0], 1);
    check("pri_lo_grant", g[1], 4'b1000);
    check("pri_lo_enc", ge[1], 3);

    // Round-robin rotation with all requesting
    cycle(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'b1111, '0);
      check("rr_rotate", g[4], rr_seq[i]);
    end

    // Acknowledge blocking
    cycle(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'b0101, '0);
      check("ack_hold", g[2], 4'b0001);
    end
    cycle(1'b1, 4'b0101, 4'b0001);
    check("ack_release", g[2], 4'b0100);
    check("ack_release_enc", ge[2], 2);
    cycle(1'b1, 4'b0101, 4'b0001);
    check("ack_foreign", g[2], 4'b0100);

    // Request blocking
    cycle(1'b0, '0, '0);
    cycle(1'b1, 4'b0100, '0);
    check("req_first", g[3], 4'b0100);
    cycle(1'b1, 4'b0101, '0);
    check("req_hold", g[3], 4'b0100);
    cycle(1'b1, 4'b0001, '0);
    check("req_drop", g[3], 4'b0001);

    // Reset mid-grant clears the rotation mask
    cycle(1'b1, 4'b0011, '0);
    cycle(1'b0, 4'b0011, '0);
    check("rst_mid_valid", gv[4], 0);
    check("rst_mid_enc", ge[4], 0);
    cycle(1'b1, 4'b1000, '0);
    check("rr_after_rst", g[4], 4'b1000);

    // Request removal
    cycle(1'b1, '0, '0);
    check("drop_valid", gv[0], 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic r;
      logic [N-1:0] req, ack;
      r   = ($urandom_range(0, 49) != 0);
      req = N'($urandom);
      ack = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      cycle(r, req, ack);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
